// File: rtl/mem_dma.sv
// Block copy / block fill initiator for the 8-bit computer's data memory.
// It drives addr/val/get/set and consumes the memory's registered out.
module mem_dma #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_val,
    output logic          mem_get,
    output logic          mem_set,
    input  logic [DW-1:0] mem_out,
    output logic          busy,
    output logic          done,
    output logic [2:0]    dbg_state
);

    // Handshake: start is a one-cycle strobe accepted only while busy=0; a
    // start seen while busy=1 is dropped, and done pulses once per accepted command.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FILL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] src_q, dst_q, len_q;
    logic [AW-1:0] idx, idx_nxt;
    logic [DW-1:0] fill_q;
    logic          last;

    assign last      = ((idx + AW'(1)) == len_q);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            fill_q <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state == S_IDLE && start) begin
                src_q  <= src;
                dst_q  <= dst;
                len_q  <= len;
                fill_q <= fill_val;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_nxt = '0;
                    if (len == '0)    state_nxt = S_DONE;
                    else if (mode)    state_nxt = S_FILL;
                    else              state_nxt = S_RD;
                end
            end
            S_RD: state_nxt = S_WR;
            S_WR: begin
                if (last) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = idx + AW'(1);
                    state_nxt = S_RD;
                end
            end
            S_FILL: begin
                if (last) state_nxt = S_DONE;
                else      idx_nxt   = idx + AW'(1);
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs decode only the state register and counters; in WR the data
    // is the memory's own registered out, fetched by the preceding RD.
    always_comb begin
        mem_get  = 1'b0;
        mem_set  = 1'b0;
        mem_addr = '0;
        mem_val  = '0;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        case (state)
            S_RD: begin
                mem_get  = 1'b1;
                mem_addr = src_q + idx;
            end
            S_WR: begin
                mem_set  = 1'b1;
                mem_addr = dst_q + idx;
                mem_val  = mem_out;
            end
            S_FILL: begin
                mem_set  = 1'b1;
                mem_addr = dst_q + idx;
                mem_val  = fill_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: behavioural memory, array-level reference model and
// a bus-operation scoreboard checked by an independent monitor.
module tb_mem_dma;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src = '0;
  logic [7:0] dst = '0;
  logic [7:0] len = '0;
  logic [7:0] fill_val = '0;
  logic [7:0] mem_addr;
  logic [7:0] mem_val;
  logic       mem_get;
  logic       mem_set;
  logic [7:0] mem_out = '0;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  logic [7:0]  tb_mem [256];
  logic [7:0]  ref_mem [256];
  logic [16:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;

  mem_dma #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .mem_addr(mem_addr), .mem_val(mem_val),
    .mem_get(mem_get), .mem_set(mem_set), .mem_out(mem_out), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // data memory: set has priority, out registered on a get edge
  always @(posedge clk) begin
    if (mem_set) tb_mem[mem_addr] = mem_val;
    else if (mem_get) mem_out <= tb_mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // monitor: every bus operation must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (mem_get && mem_set) check("get_set_exclusive", 1, 0);
      if (mem_get || mem_set) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bus_op", {15'd0, mem_set, mem_addr, mem_val}, 0);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("bus_op", {15'd0, mem_set, mem_addr, (mem_set ? mem_val : 8'h00)}, {15'd0, e});
        end
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] v);
    tb_mem[a]  = v;
    ref_mem[a] = v;
  endtask

  task automatic check_image();
    int mism = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
    check("mem_image_mismatches", mism, 0);
  endtask

  // driver: model the command, issue it, bound the wait for done
  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] l, input logic [7:0] fv, input int extra_at);
    int n = 0;
    int lat;
    int done0;
    bit seen = 0;
    for (int i = 0; i < int'(l); i++) begin
      logic [7:0] a_s, a_d, v;
      a_s = s + 8'(i);
      a_d = d + 8'(i);
      if (m) begin
        v = fv;
      end else begin
        v = ref_mem[a_s];
        exp_q.push_back({1'b0, a_s, 8'h00});
      end
      ref_mem[a_d] = v;
      exp_q.push_back({1'b1, a_d, v});
    end
    lat   = m ? int'(l) + 1 : 2 * int'(l) + 1;
    done0 = done_cnt;
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fill_val = fv; start = 1'b1;
    while (!seen && n < 600) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (extra_at != 0 && n == extra_at) begin
        start = 1'b1; mode = ~m; dst = 8'hC0; len = 8'd2; fill_val = 8'hEE;
      end
      if (extra_at != 0 && n == extra_at + 1) start = 1'b0;
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    check("done_latency", n, lat);
    check("busy_at_done", busy, 1);
    @(negedge clk);
    check("idle_after_done", {busy, done, mem_get, mem_set}, 0);
    check("done_pulses", done_cnt - done0, 1);
    check("ops_drained", exp_q.size(), 0);
    exp_q.delete();
    check_image();
  endtask

  task automatic reset_mid_copy();
    int done0;
    logic [7:0] v0;
    v0 = ref_mem[8'h50];
    ref_mem[8'h60] = v0;
    exp_q.push_back({1'b0, 8'h50, 8'h00});
    exp_q.push_back({1'b1, 8'h60, v0});
    exp_q.push_back({1'b0, 8'h51, 8'h00});
    exp_q.push_back({1'b1, 8'h61, ref_mem[8'h51]});
    done0 = done_cnt;
    @(negedge clk);
    mode = 1'b0; src = 8'h50; dst = 8'h60; len = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_get", mem_get, 0);
    check("rst_mid_set", mem_set, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pending_wr", exp_q.size(), 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", done_cnt - done0, 0);
    check_image();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    repeat (3) @(negedge clk);
    check("reset_outputs", {mem_get, mem_set, busy, done}, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_val", mem_val, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // fill 0x10..0x13 with 0xA5
    run_cmd(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 0);
    check("fill_0x13", tb_mem[8'h13], 8'hA5);
    // copy {1,2,3}
    preload(8'h20, 8'd1); preload(8'h21, 8'd2); preload(8'h22, 8'd3);
    run_cmd(1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 0);
    check("copy_0x42", tb_mem[8'h42], 8'd3);
    // wrap past 0xFF
    preload(8'h01, 8'h77);
    run_cmd(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5C, 0);
    check("wrap_0x00", tb_mem[8'h00], 8'h5C);
    check("wrap_0x01_untouched", tb_mem[8'h01], 8'h77);
    // zero length
    run_cmd(1'b0, 8'h33, 8'h44, 8'd0, 8'h00, 0);
    // start while busy must be ignored
    run_cmd(1'b0, 8'h80, 8'h90, 8'd8, 8'h00, 3);
    // overlapping forward copy
    preload(8'h30, 8'd9); preload(8'h31, 8'd8); preload(8'h32, 8'd7); preload(8'h33, 8'd6);
    run_cmd(1'b0, 8'h30, 8'h31, 8'd3, 8'h00, 0);
    check("overlap_0x33", tb_mem[8'h33], 8'd9);
    // reset mid-copy then a fresh fill
    reset_mid_copy();
    run_cmd(1'b1, 8'h00, 8'hA0, 8'd6, 8'h3C, 0);
    // randomized commands
    for (int k = 0; k < 10; k++) begin
      run_cmd(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 24)),
              8'($urandom), 0);
    end
    // one long fill at maximum length
    run_cmd(1'b1, 8'h00, 8'h05, 8'd255, 8'h81, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
